// File: rtl/overflow_underflow_rectifier.sv
// overflow_underflow_rectifier
//
// Registered signed saturation stage. Narrows a wide two's-complement value
// (accumulator / neuron sum) to a narrower two's-complement word, clamping
// out-of-range values to the most positive or most negative representable
// value instead of letting them wrap.
//
// Parameters:
//   UNRECTIFIED_DATA_WIDTH  width of the signed input word (must exceed
//                           RECTIFIED_DATA_WIDTH)
//   RECTIFIED_DATA_WIDTH    width of the signed output word (at least 2)
//
// Ports:
//   clk_in              sole clock, rising edge
//   rst_n_in            asynchronous active-low reset, clears the output to 0
//   unrectified_num_in  signed input value to be narrowed
//   rectified_num_out   registered, saturated signed result (1 clock latency)

module overflow_underflow_rectifier #(
    parameter int UNRECTIFIED_DATA_WIDTH = 32,
    parameter int RECTIFIED_DATA_WIDTH   = 16
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic [UNRECTIFIED_DATA_WIDTH-1:0] unrectified_num_in,
    output logic [RECTIFIED_DATA_WIDTH-1:0]   rectified_num_out
);

    localparam int U = UNRECTIFIED_DATA_WIDTH;
    localparam int R = RECTIFIED_DATA_WIDTH;

    localparam logic [R-1:0] SAT_MAX = {1'b0, {(R-1){1'b1}}};
    localparam logic [R-1:0] SAT_MIN = {1'b1, {(R-1){1'b0}}};

    logic [U-R:0] upper_bits;
    logic         in_range;
    logic         sign_bit;
    logic [R-1:0] rect_d;
    logic [R-1:0] rect_q;

    // The value fits in R signed bits exactly when everything from the output
    // sign position up to the input sign bit is a pure sign extension.
    assign upper_bits = unrectified_num_in[U-1:R-1];
    assign in_range   = (&upper_bits) | ~(|upper_bits);
    assign sign_bit   = unrectified_num_in[U-1];

    always_comb begin
        rect_d = unrectified_num_in[R-1:0];
        if (!in_range) begin
            rect_d = sign_bit ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rect_q <= '0;
        end else begin
            rect_q <= rect_d;
        end
    end

    assign rectified_num_out = rect_q;

endmodule

// File: tb/tb_overflow_underflow_rectifier.sv
module tb_overflow_underflow_rectifier;

    typedef struct {
        string       name;
        logic [31:0] din;
        logic [15:0] exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] din;
    logic [15:0] dout;

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] exp_q[$];
    string       name_q[$];

    vec_t tbl[12];

    overflow_underflow_rectifier #(
        .UNRECTIFIED_DATA_WIDTH(32),
        .RECTIFIED_DATA_WIDTH  (16)
    ) dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .unrectified_num_in(din),
        .rectified_num_out (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: plain signed integer range compare.
    function automatic logic [15:0] sat_model(input logic [31:0] x);
        int v;
        v = $signed(x);
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return x[15:0];
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Pipelined scoreboard: at each falling edge compare the output produced
    // by the previous input, then drive the next input and push its expectation.
    task automatic stream_step(input string name, input logic [31:0] x, input logic [15:0] e);
        @(negedge clk);
        if (exp_q.size() > 0) check(name_q.pop_front(), dout, exp_q.pop_front());
        din = x;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic stream_drain();
        while (exp_q.size() > 0) begin
            @(negedge clk);
            check(name_q.pop_front(), dout, exp_q.pop_front());
        end
    endtask

    initial begin
        logic [31:0] r;

        tbl[0]  = '{"full_pos",    32'h7FFF_FFFF, 16'h7FFF};
        tbl[1]  = '{"full_neg",    32'h8000_0000, 16'h8000};
        tbl[2]  = '{"max_plus1",   32'h0000_8000, 16'h7FFF};
        tbl[3]  = '{"min_minus1",  32'hFFFF_7FFF, 16'h8000};
        tbl[4]  = '{"exact_max",   32'h0000_7FFF, 16'h7FFF};
        tbl[5]  = '{"exact_min",   32'hFFFF_8000, 16'h8000};
        tbl[6]  = '{"pos_12345",   32'd12345,     16'h3039};
        tbl[7]  = '{"neg_12345",   32'hFFFF_CFC7, 16'hCFC7};
        tbl[8]  = '{"zero",        32'h0000_0000, 16'h0000};
        tbl[9]  = '{"minus_one",   32'hFFFF_FFFF, 16'hFFFF};
        tbl[10] = '{"high_bit_only", 32'h0001_0000, 16'h7FFF};
        tbl[11] = '{"neg_big",     32'hFFFE_FFFF, 16'h8000};

        // Reset held with a live input: output stays 0 regardless of edges.
        rst_n = 1'b0;
        din   = 32'd12345;
        #1 check("reset_async_t0", dout, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", dout, 16'h0000);
        end
        rst_n = 1'b1;
        #1 check("reset_release_no_edge", dout, 16'h0000);
        @(posedge clk);
        #1 check("reset_release_first_edge", dout, 16'h3039);

        // Table vectors streamed back to back, one per clock.
        for (int i = 0; i < 12; i++) stream_step(tbl[i].name, tbl[i].din, tbl[i].exp);
        stream_drain();

        // Random values spread over magnitudes so both in-range and clamped
        // cases show up.
        for (int i = 0; i < 24; i++) begin
            r = $urandom;
            r = 32'($signed(r) >>> $urandom_range(0, 22));
            stream_step("random", r, sat_model(r));
        end
        stream_drain();

        // Latency: output changes on exactly the next rising edge.
        @(negedge clk);
        din = 32'h7FFF_FFFF;
        @(posedge clk);
        #1 check("latency_first", dout, 16'h7FFF);
        @(negedge clk);
        din = 32'h8000_0000;
        #1 check("latency_hold_before_edge", dout, 16'h7FFF);
        @(posedge clk);
        #1 check("latency_next_edge", dout, 16'h8000);

        // Mid-cycle reset clears the output before the next edge and holds it.
        @(negedge clk);
        din = 32'h0000_1234;
        @(posedge clk);
        #1 check("pre_reset_value", dout, 16'h1234);
        #2 rst_n = 1'b0;
        #1 check("midcycle_reset_clear", dout, 16'h0000);
        @(negedge clk);
        check("midcycle_reset_hold", dout, 16'h0000);
        din = 32'h0000_0100;
        @(posedge clk);
        #1 check("reset_blocks_edge", dout, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("post_reset_load", dout, 16'h0100);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
